// File: rtl/clock_ratio_detector_m_if.sv
// Bus bundle for the clock ratio detector: stimulus in, measurement results out.
interface clock_ratio_detector_m_if #(parameter int CNT_W = 4);
  logic             enable;
  logic             divclk_in;
  logic             rise_strobe;
  logic             fall_strobe;
  logic             locked;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [1:0]       div_code;
  logic             err;
  logic             timeout;

  modport master (
    output enable, divclk_in,
    input  rise_strobe, fall_strobe, locked, period, high_time, div_code, err, timeout
  );

  modport slave (
    input  enable, divclk_in,
    output rise_strobe, fall_strobe, locked, period, high_time, div_code, err, timeout
  );
endinterface

// File: rtl/clock_ratio_detector_m.sv
// Measures a divided clock against clkin: edge strobes, period/high-time
// measurement, lock detection once the period is stable, and health pulses
// (err on period change while locked, timeout when the divided clock stalls).
module clock_ratio_detector_m #(
  parameter int CNT_W      = 4,
  parameter int LOCK_COUNT = 4
) (
  input logic                     clkin,
  input logic                     reset,
  clock_ratio_detector_m_if.slave bus
);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_CONFIRM, ST_LOCKED} state_t;

  state_t             state;
  logic               s1, s2, s3;
  logic               rise, fall;
  logic               rise_q, fall_q;
  logic [CNT_W-1:0]   cnt, cand, period_q, high_time_q;
  logic [MATCH_W-1:0] match, match_nxt;
  logic               locked_q, err_q, timeout_q;
  logic [1:0]         div_code;

  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;
  assign match_nxt = match + MATCH_W'(1);

  // Synchronize divclk_in and register the edge strobes; chain runs even when disabled.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1     <= bus.divclk_in;
      s2     <= s1;
      s3     <= s2;
      rise_q <= rise & bus.enable;
      fall_q <= fall & bus.enable;
    end
  end

  // Period counter, high-time capture and the lock FSM with its registered outputs.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cand        <= '0;
      match       <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      if (!bus.enable) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        locked_q <= 1'b0;
      end else begin
        // cnt value seen at a rise is the number of cycles since the previous rise
        if (rise)                  cnt <= CNT_W'(1);
        else if (state == ST_IDLE) cnt <= '0;
        else if (cnt != CNT_MAX)   cnt <= cnt + CNT_W'(1);

        if (fall && (state == ST_CONFIRM || state == ST_LOCKED))
          high_time_q <= cnt;

        // a rise coinciding with saturation is a valid (long) period, not a stall
        if (!rise && cnt == CNT_MAX && state != ST_IDLE) begin
          state     <= ST_IDLE;
          locked_q  <= 1'b0;
          timeout_q <= 1'b1;
        end else if (rise) begin
          case (state)
            ST_IDLE: state <= ST_MEASURE;
            ST_MEASURE: begin
              cand  <= cnt;
              match <= '0;
              state <= ST_CONFIRM;
            end
            ST_CONFIRM: begin
              if (cnt == cand) begin
                match <= match_nxt;
                if (match_nxt == MATCH_W'(LOCK_COUNT)) begin
                  state    <= ST_LOCKED;
                  locked_q <= 1'b1;
                  period_q <= cand;
                end
              end else begin
                cand  <= cnt;
                match <= '0;
              end
            end
            ST_LOCKED: begin
              if (cnt != period_q) begin
                err_q    <= 1'b1;
                locked_q <= 1'b0;
                cand     <= cnt;
                match    <= '0;
                state    <= ST_CONFIRM;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Divide code only reported while locked; period keeps its last locked value.
  always_comb begin
    div_code = 2'b00;
    if (locked_q) begin
      case (period_q)
        CNT_W'(2): div_code = 2'b01;
        CNT_W'(4): div_code = 2'b10;
        CNT_W'(8): div_code = 2'b11;
        default:   div_code = 2'b00;
      endcase
    end
  end

  assign bus.rise_strobe = rise_q;
  assign bus.fall_strobe = fall_q;
  assign bus.locked      = locked_q;
  assign bus.period      = period_q;
  assign bus.high_time   = high_time_q;
  assign bus.div_code    = div_code;
  assign bus.err         = err_q;
  assign bus.timeout     = timeout_q;
endmodule
